mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 64 ++++++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Command encoding and the request/response bundle between the L1 caches,
// the memory port and the mem_arbiter block.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_cmd_e;
endpackage

interface mem_arbiter_if #(parameter int TAG_W = 4);
  import mem_arbiter_pkg::*;

  logic             ic_req_valid;
  logic [31:0]      ic_req_addr;
  logic             ic_req_accepted;
  logic             ic_resp_valid;
  logic [31:0]      ic_resp_addr;
  logic [63:0]      ic_resp_data;

  logic             dc_req_valid;
  mem_cmd_e         dc_req_cmd;
  logic [31:0]      dc_req_addr;
  logic [63:0]      dc_req_data;
  logic             dc_req_accepted;
  logic             dc_resp_valid;
  logic [31:0]      dc_resp_addr;
  logic [63:0]      dc_resp_data;

  logic             mispredict;

  mem_cmd_e         proc2mem_command;
  logic [31:0]      proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [TAG_W-1:0] mem2proc_transaction_tag;
  logic [TAG_W-1:0] mem2proc_data_tag;
  logic [63:0]      mem2proc_data;

  logic [TAG_W:0]   ic_outstanding;

  // Arbiter side.
  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_accepted, ic_resp_valid, ic_resp_addr, ic_resp_data,
    input  dc_req_valid, dc_req_cmd, dc_req_addr, dc_req_data,
    output dc_req_accepted, dc_resp_valid, dc_resp_addr, dc_resp_data,
    input  mispredict,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_transaction_tag, mem2proc_data_tag, mem2proc_data,
    output ic_outstanding
  );

  // Cache / memory side.
  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_accepted, ic_resp_valid, ic_resp_addr, ic_resp_data,
    output dc_req_valid, dc_req_cmd, dc_req_addr, dc_req_data,
    input  dc_req_accepted, dc_resp_valid, dc_resp_addr, dc_resp_data,
    output mispredict,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_transaction_tag, mem2proc_data_tag, mem2proc_data,
    input  ic_outstanding
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one tagged memory port between icache and dcache: dcache-first
// arbitration with icache anti-starvation, and a tag table routing fills back.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << TAG_W;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_e;

  typedef struct packed {
    logic        valid;
    owner_e      owner;
    logic        squash;
    logic [31:0] addr;
  } entry_t;

  entry_t         table_q [DEPTH];
  entry_t         table_d [DEPTH];
  logic [SW-1:0]  starve_q, starve_d;
  logic [TAG_W:0] ic_out_q, ic_out_d;

  logic             ic_starved, ic_eligible, grant_ic, grant_dc;
  logic             ic_acc, dc_acc, alloc, resp_hit;
  logic [TAG_W-1:0] xtag, dtag;
  entry_t           hit_entry;

  // Arbitration and response lookup; reset forces every combinational output low.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    xtag        = bus.mem2proc_transaction_tag;
    dtag        = bus.mem2proc_data_tag;
    ic_starved  = (starve_q >= SW'(STARVE_LIMIT));
    ic_eligible = bus.ic_req_valid && !bus.mispredict;
    grant_ic    = reset && ic_eligible && (!bus.dc_req_valid || ic_starved);
    grant_dc    = reset && bus.dc_req_valid && !grant_ic;
    ic_acc      = grant_ic && (xtag != '0);
    dc_acc      = grant_dc && (xtag != '0);
    alloc       = ic_acc || (dc_acc && bus.dc_req_cmd == MEM_LOAD);
    hit_entry   = table_q[dtag];
    resp_hit    = reset && (dtag != '0) && hit_entry.valid;
  end

  always_comb begin
    bus.proc2mem_command = MEM_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    if (grant_dc) begin
      bus.proc2mem_command = bus.dc_req_cmd;
      bus.proc2mem_addr    = bus.dc_req_addr;
      bus.proc2mem_data    = bus.dc_req_data;
    end else if (grant_ic) begin
      bus.proc2mem_command = MEM_LOAD;
      bus.proc2mem_addr    = bus.ic_req_addr;
    end

    bus.ic_req_accepted = ic_acc;
    bus.dc_req_accepted = dc_acc;

    // A squashed fill, or one racing a mispredict, is dropped silently.
    bus.ic_resp_valid = resp_hit && hit_entry.owner == OWN_IC && !hit_entry.squash
                        && !bus.mispredict;
    bus.ic_resp_addr  = bus.ic_resp_valid ? hit_entry.addr : '0;
    bus.ic_resp_data  = bus.ic_resp_valid ? bus.mem2proc_data : '0;
    bus.dc_resp_valid = resp_hit && hit_entry.owner == OWN_DC;
    bus.dc_resp_addr  = bus.dc_resp_valid ? hit_entry.addr : '0;
    bus.dc_resp_data  = bus.dc_resp_valid ? bus.mem2proc_data : '0;

    bus.ic_outstanding = ic_out_q;
  end

  // Free, then squash, then allocate: a same-tag allocate overrides the free.
  always_comb begin
    table_d = table_q;
    if (resp_hit) table_d[dtag].valid = 1'b0;
    if (bus.mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (table_d[i].valid && table_d[i].owner == OWN_IC) table_d[i].squash = 1'b1;
      end
    end
    if (alloc) begin
      table_d[xtag] = '{valid:  1'b1,
                        owner:  ic_acc ? OWN_IC : OWN_DC,
                        squash: 1'b0,
                        addr:   ic_acc ? bus.ic_req_addr : bus.dc_req_addr};
    end

    if (bus.ic_req_valid && !ic_acc) starve_d = ic_starved ? starve_q : starve_q + SW'(1);
    else                             starve_d = '0;

    // Registering the next-state count makes ic_outstanding track the table itself.
    ic_out_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (table_d[i].valid && table_d[i].owner == OWN_IC && !table_d[i].squash)
        ic_out_d = ic_out_d + (TAG_W + 1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the tag table is reset in full; a stale valid bit would answer data tags issued before reset.
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      starve_q <= '0;
      ic_out_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      table_q  <= table_d;
      starve_q <= starve_d;
      ic_out_q <= ic_out_d;
    end
  end

  always @(posedge clock) begin
    if (reset && dtag != '0)
      assert (hit_entry.valid)
      else $warning("mem_arbiter: data tag %0d has no live entry, ignored", dtag);
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic, compared each cycle against a
// transaction-level model of the arbiter and its outstanding-tag book.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TAG_W = 4;
  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << TAG_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.TAG_W(TAG_W)) bus ();

  mem_arbiter #(.TAG_W(TAG_W), .STARVE_LIMIT(LIMIT)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: which tags memory still owes us, and to whom.
  typedef struct {
    bit          live;
    bit          is_ic;
    bit          dead;
    logic [31:0] addr;
  } pend_t;

  pend_t book [DEPTH];
  int    starve = 0;

  logic [1:0]  e_cmd;
  logic [31:0] e_addr, e_icra, e_dcra;
  logic [63:0] e_data, e_icrd, e_dcrd;
  bit          e_ica, e_dca, e_icr, e_dcr;

  task automatic clear_book();
    foreach (book[i]) book[i] = '{1'b0, 1'b0, 1'b0, 32'h0};
    starve = 0;
  endtask

  task automatic idle();
    bus.ic_req_valid = 0; bus.ic_req_addr = '0;
    bus.dc_req_valid = 0; bus.dc_req_cmd = MEM_LOAD; bus.dc_req_addr = '0; bus.dc_req_data = '0;
    bus.mispredict = 0;
    bus.mem2proc_transaction_tag = '0; bus.mem2proc_data_tag = '0; bus.mem2proc_data = '0;
  endtask

  // Inputs are set just after a rising edge; outputs are judged mid-cycle.
  task automatic eval();
    int dt;
    bit win_ic, win_dc, ic_wants;
    #3;
    e_cmd = MEM_NONE; e_addr = '0; e_data = '0;
    e_ica = 0; e_dca = 0; e_icr = 0; e_dcr = 0;
    e_icra = '0; e_dcra = '0; e_icrd = '0; e_dcrd = '0;
    win_ic = 0; win_dc = 0;
    if (rst_n) begin
      ic_wants = bus.ic_req_valid && !bus.mispredict;
      if (ic_wants && (!bus.dc_req_valid || starve >= LIMIT)) win_ic = 1;
      else if (bus.dc_req_valid) win_dc = 1;
      if (win_ic) begin e_cmd = MEM_LOAD; e_addr = bus.ic_req_addr; end
      if (win_dc) begin
        e_cmd = bus.dc_req_cmd; e_addr = bus.dc_req_addr; e_data = bus.dc_req_data;
      end
      e_ica = win_ic && bus.mem2proc_transaction_tag != 0;
      e_dca = win_dc && bus.mem2proc_transaction_tag != 0;
      dt = int'(bus.mem2proc_data_tag);
      if (dt != 0 && book[dt].live) begin
        if (!book[dt].is_ic) begin
          e_dcr = 1; e_dcra = book[dt].addr; e_dcrd = bus.mem2proc_data;
        end else if (!book[dt].dead && !bus.mispredict) begin
          e_icr = 1; e_icra = book[dt].addr; e_icrd = bus.mem2proc_data;
        end
      end
    end
    check("proc2mem_command", bus.proc2mem_command, e_cmd);
    check("proc2mem_addr",    bus.proc2mem_addr,    e_addr);
    check("proc2mem_data",    bus.proc2mem_data,    e_data);
    check("ic_req_accepted",  bus.ic_req_accepted,  e_ica);
    check("dc_req_accepted",  bus.dc_req_accepted,  e_dca);
    check("ic_resp_valid",    bus.ic_resp_valid,    e_icr);
    check("ic_resp_addr",     bus.ic_resp_addr,     e_icra);
    check("ic_resp_data",     bus.ic_resp_data,     e_icrd);
    check("dc_resp_valid",    bus.dc_resp_valid,    e_dcr);
    check("dc_resp_addr",     bus.dc_resp_addr,     e_dcra);
    check("dc_resp_data",     bus.dc_resp_data,     e_dcrd);
  endtask

  task automatic commit();
    int dt, tt, cnt;
    dt = int'(bus.mem2proc_data_tag);
    tt = int'(bus.mem2proc_transaction_tag);
    @(posedge clk);
    if (rst_n) begin
      if (dt != 0) book[dt].live = 0;
      if (bus.mispredict)
        foreach (book[i]) if (book[i].live && book[i].is_ic) book[i].dead = 1;
      if (e_ica) book[tt] = '{1'b1, 1'b1, 1'b0, bus.ic_req_addr};
      if (e_dca && bus.dc_req_cmd == MEM_LOAD) book[tt] = '{1'b1, 1'b0, 1'b0, bus.dc_req_addr};
      if (bus.ic_req_valid && !e_ica) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else starve = 0;
    end
    #1;
    cnt = 0;
    foreach (book[i]) if (book[i].live && book[i].is_ic && !book[i].dead) cnt++;
    check("ic_outstanding", bus.ic_outstanding, cnt);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    clear_book();
    eval();
    @(posedge clk);
    #1;
    check("reset_ic_outstanding", bus.ic_outstanding, 0);
    rst_n = 1;
  endtask

  task automatic rand_inputs();
    int s, t;
    idle();
    bus.ic_req_valid = $urandom_range(0, 2) != 0;
    bus.ic_req_addr  = $urandom;
    bus.dc_req_valid = $urandom_range(0, 1);
    bus.dc_req_cmd   = $urandom_range(0, 1) ? MEM_STORE : MEM_LOAD;
    bus.dc_req_addr  = $urandom;
    bus.dc_req_data  = {$urandom, $urandom};
    bus.mispredict   = $urandom_range(0, 9) == 0;
    bus.mem2proc_data = {$urandom, $urandom};
    if ($urandom_range(0, 1) != 0) begin
      s = $urandom_range(1, DEPTH - 1);
      for (int k = 0; k < DEPTH - 1; k++) begin
        t = 1 + (s - 1 + k) % (DEPTH - 1);
        if (book[t].live) begin bus.mem2proc_data_tag = TAG_W'(t); break; end
      end
    end
    if ($urandom_range(0, 3) != 0) begin
      s = $urandom_range(1, DEPTH - 1);
      for (int k = 0; k < DEPTH - 1; k++) begin
        t = 1 + (s - 1 + k) % (DEPTH - 1);
        if (!book[t].live || t == int'(bus.mem2proc_data_tag)) begin
          bus.mem2proc_transaction_tag = TAG_W'(t); break;
        end
      end
    end
  endtask

  initial begin
    idle();
    clear_book();
    eval();
    @(posedge clk); #1;
    check("reset_ic_outstanding", bus.ic_outstanding, 0);
    rst_n = 1;

    // dcache beats icache; its load returns on tag 3.
    idle();
    bus.dc_req_valid = 1; bus.dc_req_cmd = MEM_LOAD; bus.dc_req_addr = 32'h100;
    bus.dc_req_data = 64'h11; bus.ic_req_valid = 1; bus.ic_req_addr = 32'h200;
    bus.mem2proc_transaction_tag = 4'd3;
    eval();
    check("s1_dc_accepted", bus.dc_req_accepted, 1);
    check("s1_addr", bus.proc2mem_addr, 32'h100);
    check("s1_ic_accepted", bus.ic_req_accepted, 0);
    commit();
    idle();
    bus.mem2proc_data_tag = 4'd3; bus.mem2proc_data = 64'hCAFE_0000_0000_0100;
    eval();
    check("s1_dc_resp_valid", bus.dc_resp_valid, 1);
    check("s1_dc_resp_addr", bus.dc_resp_addr, 32'h100);
    commit();

    // Four denials, then the starved icache wins and the counter clears.
    idle();
    bus.dc_req_valid = 1; bus.dc_req_cmd = MEM_STORE; bus.dc_req_addr = 32'h300;
    bus.dc_req_data = 64'h33; bus.ic_req_valid = 1; bus.ic_req_addr = 32'h200;
    bus.mem2proc_transaction_tag = 4'd1;
    repeat (4) begin
      eval(); check("s2_ic_denied", bus.ic_req_accepted, 0); commit();
    end
    eval();
    check("s2_ic_granted", bus.ic_req_accepted, 1);
    check("s2_ic_addr", bus.proc2mem_addr, 32'h200);
    commit();
    bus.mem2proc_transaction_tag = 4'd2;
    eval(); check("s2_dc_after_clear", bus.dc_req_accepted, 1); commit();
    idle(); bus.mem2proc_data_tag = 4'd1;
    eval(); check("s2_ic_fill", bus.ic_resp_addr, 32'h200); commit();

    // Mispredict squashes an outstanding icache load.
    idle(); bus.ic_req_valid = 1; bus.ic_req_addr = 32'h500; bus.mem2proc_transaction_tag = 4'd5;
    eval(); check("s3_ic_accepted", bus.ic_req_accepted, 1); commit();
    check("s3_outstanding_1", bus.ic_outstanding, 1);
    idle(); bus.mispredict = 1;
    eval(); commit();
    check("s3_outstanding_0", bus.ic_outstanding, 0);
    idle(); eval(); commit();
    idle(); bus.mem2proc_data_tag = 4'd5; bus.mem2proc_data = 64'h55;
    eval(); check("s3_no_ic_resp", bus.ic_resp_valid, 0); commit();

    // Memory busy for three cycles, then accepts on tag 7.
    idle(); bus.ic_req_valid = 1; bus.ic_req_addr = 32'h700;
    repeat (3) begin
      eval(); check("s4_busy", bus.ic_req_accepted, 0); commit();
    end
    bus.mem2proc_transaction_tag = 4'd7;
    eval(); check("s4_accepted", bus.ic_req_accepted, 1); commit();
    idle(); bus.mem2proc_data_tag = 4'd7; eval(); commit();

    // Same-tag free and allocate in one cycle.
    idle(); bus.ic_req_valid = 1; bus.ic_req_addr = 32'h220; bus.mem2proc_transaction_tag = 4'd2;
    eval(); commit();
    idle(); bus.ic_req_valid = 1; bus.ic_req_addr = 32'h240;
    bus.mem2proc_transaction_tag = 4'd2; bus.mem2proc_data_tag = 4'd2; bus.mem2proc_data = 64'h22;
    eval();
    check("s5_resp_valid", bus.ic_resp_valid, 1);
    check("s5_resp_addr", bus.ic_resp_addr, 32'h220);
    check("s5_accepted", bus.ic_req_accepted, 1);
    commit();
    check("s5_outstanding", bus.ic_outstanding, 1);
    idle(); bus.mem2proc_data_tag = 4'd2;
    eval(); check("s5_new_addr", bus.ic_resp_addr, 32'h240); commit();

    // Reset with three loads in flight; an old tag afterwards gets no answer.
    for (int t = 8; t <= 10; t++) begin
      idle(); bus.ic_req_valid = 1; bus.ic_req_addr = 32'(t) << 8;
      bus.mem2proc_transaction_tag = TAG_W'(t);
      eval(); commit();
    end
    check("s6_outstanding_3", bus.ic_outstanding, 3);
    idle(); bus.ic_req_valid = 1; bus.ic_req_addr = 32'hB00; bus.dc_req_valid = 1;
    bus.dc_req_addr = 32'hC00; bus.mem2proc_transaction_tag = 4'd4;
    apply_reset();
    idle(); bus.mem2proc_data_tag = 4'd8; bus.mem2proc_data = 64'h88;
    eval(); check("s6_no_stale_resp", bus.ic_resp_valid, 0); commit();

    // Randomized traffic.
    repeat (500) begin
      rand_inputs();
      if ($urandom_range(0, 149) == 0) apply_reset();
      else begin eval(); commit(); end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
